// File: rtl/digit_scan_if.sv
// Bundle between the display scanner and its neighbours: frame digits and
// blink controls in, one multiplexed digit with its enable out.
interface digit_scan_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blink_phase;
    logic [3:0]              digit_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_start;

    modport master (
        output digits_in, blink_mask, blink_phase,
        input  digit_out, digit_en, frame_start
    );

    modport slave (
        input  digits_in, blink_mask, blink_phase,
        output digit_out, digit_en, frame_start
    );
endinterface

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner: alternates BLANK guard and DRIVE phases per
// digit, snapshots the frame at digit 0 and blanks digits selected for blinking.
module digit_scan_mux #(
    parameter int NUM_DIGITS   = 6,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    digit_scan_if.slave  bus
);
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] snap_reg, snap_next;
    logic [3:0]              out_reg, out_next;
    logic [NUM_DIGITS-1:0]   en_reg, en_next;
    logic                    fs_reg, fs_next;

    logic [3:0]              snap_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   en_dec;

    // Decode against the *next* index/snapshot so the registered outputs line
    // up with the state register in the same cycle.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign snap_nib[gi] = snap_next[4*gi +: 4];
        assign en_dec[gi]   = (idx_next == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BLANK;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            snap_reg  <= '0;
            out_reg   <= 4'hF;
            en_reg    <= '0;
            fs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            snap_reg  <= snap_next;
            out_reg   <= out_next;
            en_reg    <= en_next;
            fs_reg    <= fs_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        snap_next  = snap_reg;
        case (state_reg)
            BLANK: begin
                if (cnt_reg == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                    if (idx_reg == '0) begin
                        snap_next = bus.digits_in;
                    end
                end
            end
            default: begin
                if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        out_next = 4'hF;
        en_next  = '0;
        fs_next  = 1'b0;
        if (state_next == DRIVE) begin
            en_next  = en_dec;
            out_next = (bus.blink_phase && bus.blink_mask[idx_next]) ? 4'hF : snap_nib[idx_next];
            fs_next  = (state_reg == BLANK) && (idx_next == '0);
        end
    end

    assign bus.digit_out   = out_reg;
    assign bus.digit_en    = en_reg;
    assign bus.frame_start = fs_reg;
endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux: a frame-position model pushes expected
// outputs per cycle, a monitor pops and compares them and checks invariants.
module tb_digit_scan_mux;
    localparam int N = 6;
    localparam int R = 4;
    localparam int G = 2;
    localparam int DP = G + R;
    localparam int P = N * DP;

    typedef struct {
        logic [3:0]   out;
        logic [N-1:0] en;
        logic         fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   checking = 1'b0;
    logic [4*N-1:0] snap = '0;
    exp_t q[$];

    digit_scan_if #(.NUM_DIGITS(N)) bus ();

    digit_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected output of cycle cyc+1 from its position inside the frame.
    task automatic step(input logic [4*N-1:0] d, input logic [N-1:0] m, input logic b);
        exp_t e;
        int c, p, dd, off;
        bit drive;
        bus.digits_in   = d;
        bus.blink_mask  = m;
        bus.blink_phase = b;
        c     = cyc + 1;
        p     = c % P;
        dd    = p / DP;
        off   = p % DP;
        drive = (off >= G);
        if (drive && dd == 0 && off == G) snap = d;
        e.en  = drive ? N'(1 << dd) : '0;
        e.out = (!drive || (b && m[dd])) ? 4'hF : snap[dd*4 +: 4];
        e.fs  = drive && dd == 0 && off == G;
        q.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        snap     = '0;
        checking = 1'b1;
        #1;
        check("reset_en", 32'(bus.digit_en), 32'h0);
        check("reset_out", 32'(bus.digit_out), 32'hF);
        check("reset_fs", 32'(bus.frame_start), 32'h0);
    endtask

    task automatic async_reset();
        #2;
        rst_n    = 1'b0;
        checking = 1'b0;
        #1;
        check("async_en", 32'(bus.digit_en), 32'h0);
        check("async_out", 32'(bus.digit_out), 32'hF);
        check("async_fs", 32'(bus.frame_start), 32'h0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard compare plus one-hot, guard-gap and frame-period checks.
    initial begin : monitor
        int mcyc, zero_run, last_fs;
        logic [N-1:0] last_nz;
        bit seen;
        exp_t e;
        mcyc = 0; zero_run = 0; last_fs = -1; last_nz = '0; seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!checking) begin
                mcyc = 0; zero_run = 0; last_fs = -1; seen = 0;
            end else begin
                mcyc++;
                if (q.size() == 0) begin
                    check("queue_underflow", 32'(q.size()), 32'h1);
                end else begin
                    e = q.pop_front();
                    $display("cyc %0d en=%b out=%h fs=%b exp en=%b out=%h fs=%b",
                             mcyc, bus.digit_en, bus.digit_out, bus.frame_start, e.en, e.out, e.fs);
                    check("digit_en", 32'(bus.digit_en), 32'(e.en));
                    check("digit_out", 32'(bus.digit_out), 32'(e.out));
                    check("frame_start", 32'(bus.frame_start), 32'(e.fs));
                end
                check("onehot", 32'($countones(bus.digit_en) <= 1), 32'h1);
                if (bus.digit_en == '0) begin
                    zero_run++;
                end else begin
                    if (seen && bus.digit_en != last_nz)
                        check("guard_gap", 32'(zero_run >= G), 32'h1);
                    seen = 1; last_nz = bus.digit_en; zero_run = 0;
                end
                if (bus.frame_start === 1'b1) begin
                    if (last_fs >= 0) check("frame_period", 32'(mcyc - last_fs), 32'(P));
                    last_fs = mcyc;
                end
            end
        end
    end

    initial begin : stimulus
        logic [4*N-1:0] d;
        logic [N-1:0] m;
        logic b;
        bus.digits_in = 24'h123456; bus.blink_mask = '0; bus.blink_phase = 1'b0;

        // First frame, wrap-around and snapshot coherence
        release_reset();
        for (int i = 0; i < 80; i++)
            step((i >= 10) ? 24'h999999 : 24'h123456, 6'b0, 1'b0);
        async_reset();

        // Blink on digits 0 and 1, then reset mid-DRIVE at cycle 9
        release_reset();
        for (int i = 0; i < 9; i++)
            step(24'h123456, 6'b000011, i >= 3);
        async_reset();
        release_reset();
        for (int i = 0; i < 40; i++)
            step(24'h123456, 6'b000011, 1'b1);
        async_reset();

        // Exact repeat of the first-frame sequence after reset
        release_reset();
        for (int i = 0; i < 40; i++)
            step(24'h123456, 6'b0, 1'b0);

        // Random digits (including non-BCD nibbles) and blink controls, 10 frames
        d = 24'($urandom); m = 6'($urandom); b = 1'b0;
        for (int i = 0; i < 10 * P; i++) begin
            if ($urandom_range(0, 7) == 0) d = 24'($urandom);
            if ($urandom_range(0, 19) == 0) m = 6'($urandom);
            if ($urandom_range(0, 9) == 0) b = ~b;
            step(d, m, b);
        end

        checking = 1'b0;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Time-multiplexed display scanner for the digital clock; sits directly upstream of the BCD-to-segment decoder.
- Holds a frame snapshot of NUM_DIGITS packed BCD digits (HH:MM:SS), selects one digit at a time onto digit_out, and drives the matching one-hot digit enable.
- Inserts a blanking guard interval between digits to suppress ghosting and supports per-digit blinking for time-set mode.

Parameters:
- NUM_DIGITS, 6, number of display digits scanned; legal range 2..8.
- REFRESH_DIV, 100000, clk cycles each digit is driven (DRIVE phase length); must be >= 1.
- GUARD_CYCLES, 1000, clk cycles all enables are off between digits (BLANK phase length); must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit i occupies bits [4i+3:4i]; digit 0 = rightmost (seconds units).
- blink_mask  input  NUM_DIGITS  bit i set = digit i participates in blinking.
- blink_phase  input  1  blink state from the upstream slow divider; 1 = blinking digits dark.
- digit_out  output  4  BCD code to the segment decoder; 4'hF = blank (decoder blanks codes above 9).
- digit_en  output  NUM_DIGITS  one-hot, active-high enable of the digit currently driven; all-zero while blanking.
- frame_start  output  1  one-cycle pulse on the first DRIVE cycle of digit 0.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Reset values: state=BLANK, idx=0, phase counter=0, snapshot=0, digit_out=4'hF, digit_en=0, frame_start=0.
- FSM states:
  - BLANK: counter counts 0..GUARD_CYCLES-1. At terminal count, go to DRIVE and clear the counter. If idx==0 on that transition, load snapshot <= digits_in.
  - DRIVE: counter counts 0..REFRESH_DIV-1. At terminal count, go to BLANK, clear the counter, and advance idx: idx+1, wrapping NUM_DIGITS-1 -> 0.
- Outputs are registered (Moore) and change only on clk edges.
- In DRIVE, cycle-accurate to the state register:
  - digit_en = 1<<idx.
  - digit_out = 4'hF if (blink_phase && blink_mask[idx]), else snapshot[4idx+3:4idx].
  - digit_out is updated every DRIVE cycle, so a blink_phase change takes effect on the next cycle even mid-digit.
- In BLANK: digit_en=0, digit_out=4'hF.
- frame_start = 1 for exactly the first DRIVE cycle with idx==0.
- Snapshot is taken only at frame start. digits_in changes mid-frame are not displayed until the next frame (no tearing). Non-BCD nibbles pass through unchanged.
- Timing: cycle 0 = first rising edge with rst_n high. First DRIVE cycle = cycle GUARD_CYCLES. Digit period = GUARD_CYCLES+REFRESH_DIV cycles. Frame period = NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV) cycles.
- Overlap rule: digit_en never has more than one bit set, and is never non-zero in two consecutive cycles with different values; a BLANK phase always separates them.
- Reset mid-DRIVE: digit_en and digit_out go to reset values immediately (asynchronous); scanning restarts from digit 0 with a full BLANK phase.
- Counters and idx are sized for their maximum values; no overflow path exists.

Test Plan:
- Reset/first frame (NUM_DIGITS=6, REFRESH_DIV=4, GUARD_CYCLES=2, digits_in=24'h123456):
  - Cycles 0-1: digit_en=0, digit_out=F.
  - Cycles 2-5: digit_en=6'b000001, digit_out=6, frame_start=1 in cycle 2 only.
  - Cycles 8-11: digit_en=6'b000010, digit_out=5.
- Wrap-around: same setup.
  - Digit 5 driven in cycles 32-35 with digit_out=1.
  - Cycles 36-37 blank.
  - Cycle 38: digit_en=6'b000001, frame_start=1.
  - Frame period measured = 36.
- Snapshot coherence: change digits_in to 24'h999999 at cycle 10.
  - Digits 1-5 of frame 1 still show 5,4,3,2,1.
  - Frame 2 (from cycle 38) shows 9 on all digits.
- Blink: blink_mask=6'b000011, blink_phase toggled high at cycle 3.
  - digit_out=F from cycle 4 onward during digits 0 and 1.
  - Digits 2-5 unaffected.
  - digit_en still one-hot throughout.
- Async reset mid-DRIVE: assert rst_n=0 at cycle 9 between edges.
  - digit_en=0 and digit_out=F without waiting for a clk edge.
  - After release, the sequence repeats exactly as in scenario 1.
- Invariant check (random digits_in, blink inputs, 10 frames):
  - digit_en always one-hot or zero.
  - At least GUARD_CYCLES zero cycles between distinct enables.
